// File: rtl/serial_add_sequencer_pkg.sv
//------------------------------------------------------------------------------
// serial_add_sequencer_pkg
// Shared FSM encoding, default sizing and FIFO occupancy helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_add_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_LAT   = DEFAULT_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } seq_state_e;

    function automatic logic [1:0] fifo_count_next(
        input logic [1:0] count,
        input logic       push,
        input logic       pop
    );
        logic [1:0] nxt;
        nxt = count;
        case ({push, pop})
            2'b10:   nxt = count + 2'd1;
            2'b01:   nxt = count - 2'd1;
            default: nxt = count;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/operand_fifo2.sv
//------------------------------------------------------------------------------
// operand_fifo2
// Two-entry operand FIFO with registered not-full and head-valid flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module operand_fifo2
    import serial_add_sequencer_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          ready_o,
    output logic          valid_o,
    output logic          nonempty_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          ready_q;
    logic          valid_q;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push = push_i && ready_q;
        do_pop  = pop_i && (count_q != 2'd0);
        count_d = fifo_count_next(count_q, do_push, do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
            // A word written into an empty FIFO is offered one cycle later.
            valid_q <= (count_d != 2'd0) && (count_q != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o     = mem_q[rd_ptr_q];
    assign ready_o    = ready_q;
    assign valid_o    = valid_q;
    assign nonempty_o = (count_q != 2'd0);

endmodule

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
//------------------------------------------------------------------------------
// serial_add_sequencer
// Buffers operand pairs, launches an external serial adder and holds results.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LAT   = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             add_start,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);

    localparam int FIFO_DW = WIDTH * 2 + 1;
    localparam int CNT_W   = $clog2(LAT + 1);

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             add_start_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic             add_cin_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_sum_q;
    logic             res_cout_q;

    logic [FIFO_DW-1:0] fifo_head;
    logic               fifo_ready;
    logic               fifo_valid;
    logic               fifo_nonempty;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic               head_cin;
    logic               res_fire;
    logic               launch_ok;

    operand_fifo2 #(
        .DW(FIFO_DW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (in_valid),
        .data_i     ({in_cin, in_b, in_a}),
        .pop_i      (launch_ok),
        .data_o     (fifo_head),
        .ready_o    (fifo_ready),
        .valid_o    (fifo_valid),
        .nonempty_o (fifo_nonempty)
    );

    assign {head_cin, head_b, head_a} = fifo_head;

    // A held result that is draining this cycle does not block the next launch.
    assign res_fire  = res_valid_q && res_ready;
    assign launch_ok = (state_q == ST_IDLE) && fifo_valid && (!res_valid_q || res_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            add_start_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
        end else begin
            add_start_q <= 1'b0;
            if (res_fire) begin
                res_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (launch_ok) begin
                        state_q     <= ST_LAUNCH;
                        add_start_q <= 1'b1;
                        add_a_q     <= head_a;
                        add_b_q     <= head_b;
                        add_cin_q   <= head_cin;
                    end
                end
                ST_LAUNCH: begin
                    if (LAT > 1) begin
                        cnt_q   <= CNT_W'(LAT - 1);
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    res_sum_q   <= add_sum;
                    res_cout_q  <= add_cout;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = fifo_ready;
    assign add_start = add_start_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign busy      = (state_q != ST_IDLE) || fifo_nonempty;

endmodule

`default_nettype wire
